npu_conv_engine: RTL and testbench



---
 rtl/npu_cnn_pkg.sv | 46 ++++
 rtl/npu_conv_engine_if.sv | 37 +++
 rtl/npu_conv_addr_gen.sv | 110 +++++++++++
 rtl/npu_conv_engine.sv | 180 ++++++++++++++++++
 tb/tb_npu_conv_engine.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/npu_cnn_pkg.sv
// Shared types, constants and output scaling for the NPU convolution core.
// Imported by the interface, the address generator and the engine top.
package npu_cnn_pkg;

    localparam int DATA_WIDTH      = 16;
    localparam int ACC_WIDTH       = 40;
    localparam int DIM_WIDTH       = 8;
    localparam int BRAM_ADDR_WIDTH = 14;
    localparam int SHIFT_WIDTH     = 5;

    typedef logic signed [DATA_WIDTH-1:0] data_t;
    typedef logic signed [ACC_WIDTH-1:0]  acc_t;
    typedef logic [DIM_WIDTH-1:0]         dim_t;
    typedef logic [BRAM_ADDR_WIDTH-1:0]   addr_t;
    typedef logic [SHIFT_WIDTH-1:0]       shift_t;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        MAC,
        DRAIN,
        WRITE,
        DONE
    } state_t;

    localparam acc_t SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam acc_t SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    // Scale the accumulator down, clamp to the data range, optional ReLU.
    function automatic data_t sat_relu(acc_t acc, shift_t shift, logic relu);
        acc_t r;
        r = acc >>> shift;
        if (r > SAT_MAX) begin
            r = SAT_MAX;
        end else if (r < SAT_MIN) begin
            r = SAT_MIN;
        end
        if (relu && r[ACC_WIDTH-1]) begin
            r = '0;
        end
        return r[DATA_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/npu_conv_engine_if.sv
// BRAM access bundle between the convolution engine and the shared memory.
// The engine is the master: it drives both read addresses and the write port.
interface npu_conv_engine_if;
    import npu_cnn_pkg::*;

    logic  rd_en;
    addr_t img_rd_addr;
    addr_t wgt_rd_addr;
    data_t img_rd_data;
    data_t wgt_rd_data;
    logic  wr_en;
    addr_t wr_addr;
    data_t wr_data;

    modport master (
        output rd_en,
        output img_rd_addr,
        output wgt_rd_addr,
        input  img_rd_data,
        input  wgt_rd_data,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        input  rd_en,
        input  img_rd_addr,
        input  wgt_rd_addr,
        output img_rd_data,
        output wgt_rd_data,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

endinterface

// File: rtl/npu_conv_addr_gen.sv
// Nested loop counters (oc, oy, ox | ic, ky, kx) and the image, weight and
// output address computations; all address math wraps at the BRAM size.
module npu_conv_addr_gen
    import npu_cnn_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  logic  step,
    input  logic  next_pix,
    input  dim_t  h,
    input  dim_t  w,
    input  dim_t  kh,
    input  dim_t  kw,
    input  dim_t  inc,
    input  dim_t  outc,
    input  addr_t img_base,
    input  addr_t wgt_base,
    input  addr_t out_base,
    output addr_t img_addr,
    output addr_t wgt_addr,
    output addr_t out_addr,
    output logic  first,
    output logic  last,
    output logic  last_pix
);

    localparam dim_t ONE = dim_t'(1);

    dim_t oh, ow;
    dim_t oc, oy, ox;
    dim_t ic, ky, kx;

    logic kx_end, ky_end, ic_end;
    logic ox_end, oy_end, oc_end;

    assign kx_end   = (kx == kw - ONE);
    assign ky_end   = (ky == kh - ONE);
    assign ic_end   = (ic == inc - ONE);
    assign ox_end   = (ox == ow - ONE);
    assign oy_end   = (oy == oh - ONE);
    assign oc_end   = (oc == outc - ONE);
    assign first    = (ic == '0) && (ky == '0) && (kx == '0);
    assign last     = ic_end && ky_end && kx_end;
    assign last_pix = oc_end && oy_end && ox_end;

    // Counters: zeroed at setup, inner loop on step, pixel loop on next_pix.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            oh <= '0;
            ow <= '0;
            oc <= '0;
            oy <= '0;
            ox <= '0;
            ic <= '0;
            ky <= '0;
            kx <= '0;
        end else if (load) begin
            oh <= h - kh + ONE;
            ow <= w - kw + ONE;
            oc <= '0;
            oy <= '0;
            ox <= '0;
            ic <= '0;
            ky <= '0;
            kx <= '0;
        end else begin
            if (step) begin
                if (kx_end) begin
                    kx <= '0;
                    if (ky_end) begin
                        ky <= '0;
                        ic <= ic_end ? '0 : ic + ONE;
                    end else begin
                        ky <= ky + ONE;
                    end
                end else begin
                    kx <= kx + ONE;
                end
            end
            if (next_pix) begin
                if (ox_end) begin
                    ox <= '0;
                    if (oy_end) begin
                        oy <= '0;
                        oc <= oc_end ? '0 : oc + ONE;
                    end else begin
                        oy <= oy + ONE;
                    end
                end else begin
                    ox <= ox + ONE;
                end
            end
        end
    end

    // Address arithmetic on zero-extended counters, truncated to BRAM width.
    always_comb begin
        img_addr = img_base
                 + (addr_t'(ic) * addr_t'(h) + addr_t'(oy) + addr_t'(ky))
                 * addr_t'(w) + addr_t'(ox) + addr_t'(kx);
        wgt_addr = wgt_base
                 + ((addr_t'(oc) * addr_t'(inc) + addr_t'(ic))
                 * addr_t'(kh) + addr_t'(ky)) * addr_t'(kw) + addr_t'(kx);
        out_addr = out_base
                 + (addr_t'(oc) * addr_t'(oh) + addr_t'(oy))
                 * addr_t'(ow) + addr_t'(ox);
    end

endmodule

// File: rtl/npu_conv_engine.sv
// Convolution compute core: valid 2-D multi-channel convolution over BRAM
// with fixed-point scaling, saturation and optional ReLU on each output.
module npu_conv_engine
    import npu_cnn_pkg::*;
(
    input  logic   S_AXI_ACLK,
    input  logic   S_AXI_ARESETN,
    input  logic   start,
    input  logic   abort,
    input  addr_t  cfg_img_base,
    input  addr_t  cfg_out_base,
    input  addr_t  cfg_wgt_base,
    input  dim_t   cfg_h,
    input  dim_t   cfg_w,
    input  dim_t   cfg_kh,
    input  dim_t   cfg_kw,
    input  dim_t   cfg_inc,
    input  dim_t   cfg_outc,
    input  shift_t cfg_shift,
    input  logic   cfg_relu,
    npu_conv_engine_if.master bram,
    output logic   busy,
    output logic   done,
    output logic   err
);

    state_t state, state_nx;

    addr_t  img_base, out_base, wgt_base;
    dim_t   h, w, kh, kw, inc, outc;
    shift_t shift;
    logic   relu;

    logic   accept, cfg_bad, drain_cnt;
    logic   first, last, last_pix;
    addr_t  img_addr, wgt_addr, out_addr;

    logic   v1, v2, f1, f2;
    acc_t   prod, acc;
    logic signed [2*DATA_WIDTH-1:0] mul;

    assign accept  = start && !abort && (state == IDLE);
    assign cfg_bad = (h == '0) || (w == '0) || (kh == '0) || (kw == '0)
                  || (inc == '0) || (outc == '0)
                  || (kh > h) || (kw > w);
    assign mul     = bram.img_rd_data * bram.wgt_rd_data;

    npu_conv_addr_gen u_addr (
        .clk      (S_AXI_ACLK),
        .rst_n    (S_AXI_ARESETN),
        .load     (state == SETUP),
        .step     (state == MAC),
        .next_pix (state == WRITE),
        .h        (h),
        .w        (w),
        .kh       (kh),
        .kw       (kw),
        .inc      (inc),
        .outc     (outc),
        .img_base (img_base),
        .wgt_base (wgt_base),
        .out_base (out_base),
        .img_addr (img_addr),
        .wgt_addr (wgt_addr),
        .out_addr (out_addr),
        .first    (first),
        .last     (last),
        .last_pix (last_pix)
    );

    // State register.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; abort wins over everything, including start.
    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (start) state_nx = SETUP;
                SETUP:   state_nx = cfg_bad ? DONE : MAC;
                MAC:     if (last) state_nx = DRAIN;
                DRAIN:   if (drain_cnt) state_nx = WRITE;
                WRITE:   state_nx = last_pix ? DONE : MAC;
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Configuration latch, error flag and the two-cycle drain counter.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            img_base  <= '0;
            out_base  <= '0;
            wgt_base  <= '0;
            h         <= '0;
            w         <= '0;
            kh        <= '0;
            kw        <= '0;
            inc       <= '0;
            outc      <= '0;
            shift     <= '0;
            relu      <= 1'b0;
            err       <= 1'b0;
            drain_cnt <= 1'b0;
        end else begin
            drain_cnt <= (state == DRAIN) && !drain_cnt;
            if (accept) begin
                img_base <= cfg_img_base;
                out_base <= cfg_out_base;
                wgt_base <= cfg_wgt_base;
                h        <= cfg_h;
                w        <= cfg_w;
                kh       <= cfg_kh;
                kw       <= cfg_kw;
                inc      <= cfg_inc;
                outc     <= cfg_outc;
                shift    <= cfg_shift;
                relu     <= cfg_relu;
                err      <= 1'b0;
            end else if (abort && state != IDLE) begin
                err <= 1'b0;
            end else if (state == SETUP && cfg_bad) begin
                err <= 1'b1;
            end
        end
    end

    // MAC pipeline: read data -> registered product -> accumulator.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            f1   <= 1'b0;
            f2   <= 1'b0;
            prod <= '0;
            acc  <= '0;
        end else begin
            v1 <= (state == MAC) && !abort;
            f1 <= (state == MAC) && first;
            v2 <= v1 && !abort;
            f2 <= f1;
            if (v1) begin
                prod <= {{(ACC_WIDTH-2*DATA_WIDTH){mul[2*DATA_WIDTH-1]}}, mul};
            end
            if (v2) begin
                acc <= f2 ? prod : acc + prod;
            end
        end
    end

    // Output decode; addresses and data are held at zero when idle.
    always_comb begin
        busy             = (state != IDLE);
        done             = (state == DONE);
        bram.rd_en       = (state == MAC);
        bram.img_rd_addr = '0;
        bram.wgt_rd_addr = '0;
        bram.wr_en       = (state == WRITE);
        bram.wr_addr     = '0;
        bram.wr_data     = '0;
        if (state == MAC) begin
            bram.img_rd_addr = img_addr;
            bram.wgt_rd_addr = wgt_addr;
        end
        if (state == WRITE) begin
            bram.wr_addr = out_addr;
            bram.wr_data = sat_relu(acc, shift, relu);
        end
    end

endmodule

// File: tb/tb_npu_conv_engine.sv
// Directed bench for npu_conv_engine: vector table of layer configs with
// hand-computed outputs, plus abort / busy-start / err-hold sequences.
module tb_npu_conv_engine;
    import npu_cnn_pkg::*;

    typedef struct {
        int h, w, kh, kw, inc, outc, sh, rl;
        int ib, wb, ob;
        int n_img, n_wgt, n_out;
        int exp_done, exp_err, exp_rd;
        logic [8:0][15:0] img;
        logic [7:0][15:0] wgt;
        logic [3:0][15:0] exp_out;
    } vec_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   start = 1'b0;
    logic   abort = 1'b0;
    addr_t  cfg_img_base = '0, cfg_out_base = '0, cfg_wgt_base = '0;
    dim_t   cfg_h = '0, cfg_w = '0, cfg_kh = '0, cfg_kw = '0;
    dim_t   cfg_inc = '0, cfg_outc = '0;
    shift_t cfg_shift = '0;
    logic   cfg_relu = 1'b0;
    logic   busy, done, err;

    logic [15:0] mem [16384];
    int cyc = 0, st = 0;
    int rd_cnt = 0, wr_cnt = 0, done_cnt = 0;
    int n_chk = 0, n_pass = 0;
    vec_t v [10];

    npu_conv_engine_if bus ();

    npu_conv_engine dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .start         (start),
        .abort         (abort),
        .cfg_img_base  (cfg_img_base),
        .cfg_out_base  (cfg_out_base),
        .cfg_wgt_base  (cfg_wgt_base),
        .cfg_h         (cfg_h),
        .cfg_w         (cfg_w),
        .cfg_kh        (cfg_kh),
        .cfg_kw        (cfg_kw),
        .cfg_inc       (cfg_inc),
        .cfg_outc      (cfg_outc),
        .cfg_shift     (cfg_shift),
        .cfg_relu      (cfg_relu),
        .bram          (bus),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: one-cycle read latency on both ports, plus write port.
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.img_rd_data <= mem[bus.img_rd_addr];
            bus.wgt_rd_data <= mem[bus.wgt_rd_addr];
        end
        if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
    end

    always @(negedge clk) begin
        if (bus.rd_en) rd_cnt++;
        if (bus.wr_en) wr_cnt++;
        if (done) done_cnt++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic vec_t mk(input int h, w, kh, kw, inc, outc,
                                input int sh, rl, ib, wb, ob,
                                input int ed, ee);
        vec_t r;
        r.h = h; r.w = w; r.kh = kh; r.kw = kw;
        r.inc = inc; r.outc = outc; r.sh = sh; r.rl = rl;
        r.ib = ib; r.wb = wb; r.ob = ob;
        r.exp_done = ed; r.exp_err = ee;
        r.n_img = inc * h * w;
        r.n_wgt = outc * inc * kh * kw;
        r.n_out = ee ? 0 : outc * (h - kh + 1) * (w - kw + 1);
        r.exp_rd = ee ? 0 : r.n_out * inc * kh * kw;
        r.img = '0; r.wgt = '0; r.exp_out = '0;
        return r;
    endfunction

    task automatic apply_cfg(input vec_t x);
        cfg_h = dim_t'(x.h); cfg_w = dim_t'(x.w);
        cfg_kh = dim_t'(x.kh); cfg_kw = dim_t'(x.kw);
        cfg_inc = dim_t'(x.inc); cfg_outc = dim_t'(x.outc);
        cfg_shift = shift_t'(x.sh); cfg_relu = x.rl[0];
        cfg_img_base = addr_t'(x.ib);
        cfg_wgt_base = addr_t'(x.wb);
        cfg_out_base = addr_t'(x.ob);
        for (int k = 0; k < x.n_img && k < 9; k++)
            mem[addr_t'(x.ib + k)] = x.img[k];
        for (int k = 0; k < x.n_wgt && k < 8; k++)
            mem[addr_t'(x.wb + k)] = x.wgt[k];
        for (int k = 0; k < 4; k++)
            mem[addr_t'(x.ob + k)] = 16'h5A5A;
    endtask

    task automatic go();
        @(negedge clk);
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
        st = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int rel);
        rel = -1;
        for (int i = 0; i < limit; i++) begin
            if (done) begin
                rel = cyc - st;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_vec(input vec_t x, input int id);
        int rel;
        apply_cfg(x);
        go();
        wait_done(300, rel);
        chk($sformatf("v%0d done_cycle", id), rel, x.exp_done);
        chk($sformatf("v%0d err_at_done", id), int'(err), x.exp_err);
        repeat (2) @(negedge clk);
        chk($sformatf("v%0d err_held", id), int'(err), x.exp_err);
        chk($sformatf("v%0d idle", id), int'(busy), 0);
        chk($sformatf("v%0d done_pulses", id), done_cnt, 1);
        chk($sformatf("v%0d rd_count", id), rd_cnt, x.exp_rd);
        chk($sformatf("v%0d wr_count", id), wr_cnt, x.n_out);
        for (int k = 0; k < x.n_out; k++)
            chk($sformatf("v%0d out%0d", id, k),
                int'(mem[addr_t'(x.ob + k)]), int'(x.exp_out[k]));
    endtask

    initial begin
        int rel;
        for (int i = 0; i < 16384; i++) mem[i] = '0;
        bus.img_rd_data = '0;
        bus.wgt_rd_data = '0;

        v[0] = mk(3, 3, 2, 2, 1, 1, 0, 0, 0, 64, 128, 30, 0);
        for (int k = 0; k < 9; k++) v[0].img[k] = 16'(k + 1);
        for (int k = 0; k < 4; k++) v[0].wgt[k] = 16'd1;
        v[0].exp_out[0] = 16'd12; v[0].exp_out[1] = 16'd16;
        v[0].exp_out[2] = 16'd24; v[0].exp_out[3] = 16'd28;

        v[1] = mk(2, 2, 2, 2, 1, 1, 0, 0, 300, 310, 320, 9, 0);
        for (int k = 0; k < 4; k++) v[1].img[k] = 16'h7FFF;
        for (int k = 0; k < 4; k++) v[1].wgt[k] = 16'h7FFF;
        v[1].exp_out[0] = 16'h7FFF;

        v[2] = v[1];
        for (int k = 0; k < 4; k++) v[2].wgt[k] = 16'h8001;
        v[2].exp_out[0] = 16'h8000;

        v[3] = v[2];
        v[3].rl = 1;
        v[3].exp_out[0] = 16'h0000;

        v[4] = mk(1, 1, 1, 1, 1, 1, 8, 0, 400, 401, 402, 6, 0);
        v[4].img[0] = 16'h0180; v[4].wgt[0] = 16'h0200;
        v[4].exp_out[0] = 16'h0300;

        v[5] = mk(1, 1, 1, 1, 2, 2, 0, 0, 100, 200, 16383, 12, 0);
        v[5].img[0] = 16'd3; v[5].img[1] = 16'd5;
        v[5].wgt[0] = 16'd1; v[5].wgt[1] = 16'd2;
        v[5].wgt[2] = 16'hFFFF; v[5].wgt[3] = 16'd1;
        v[5].exp_out[0] = 16'd13; v[5].exp_out[1] = 16'd2;

        v[6] = mk(3, 3, 4, 1, 1, 1, 0, 0, 700, 710, 720, 2, 1);

        v[7] = mk(1, 1, 1, 1, 1, 1, 4, 0, 500, 501, 502, 6, 0);
        v[7].img[0] = 16'hFF00; v[7].wgt[0] = 16'h0001;
        v[7].exp_out[0] = 16'hFFF0;

        v[8] = mk(2, 2, 1, 1, 0, 1, 0, 0, 800, 810, 820, 2, 1);

        v[9] = v[4];

        repeat (3) @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset err", int'(err), 0);
        chk("reset rd_en", int'(bus.rd_en), 0);
        chk("reset wr_en", int'(bus.wr_en), 0);
        chk("reset wr_data", int'(bus.wr_data), 0);
        chk("reset img_addr", int'(bus.img_rd_addr), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_vec(v[i], i);

        // Abort in cycle 5 of the first case: no done, no writes.
        apply_cfg(v[0]);
        go();
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort idle", int'(busy), 0);
        chk("abort err", int'(err), 0);
        repeat (40) @(negedge clk);
        chk("abort done_pulses", done_cnt, 0);
        chk("abort wr_count", wr_cnt, 0);
        chk("abort rd_count", rd_cnt, 4);
        chk("abort out0", int'(mem[128]), 16'h5A5A);

        // Abort and start together while idle: nothing starts.
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort+start idle", int'(busy), 0);

        // Restart first case; cfg changes and start while busy are ignored.
        apply_cfg(v[0]);
        mem[600] = 16'h0;
        go();
        cfg_h = 8'd5; cfg_kh = 8'd1; cfg_out_base = 14'd600;
        repeat (9) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(300, rel);
        chk("busy-start done_cycle", rel, 30);
        repeat (4) @(negedge clk);
        chk("busy-start done_pulses", done_cnt, 1);
        chk("busy-start wr_count", wr_cnt, 4);
        chk("busy-start rd_count", rd_cnt, 16);
        chk("busy-start stray", int'(mem[600]), 0);
        for (int k = 0; k < 4; k++)
            chk($sformatf("busy-start out%0d", k),
                int'(mem[128 + k]), int'(v[0].exp_out[k]));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
